// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: memory-op encodings, mem-stage FSM
// states and small op-classification helpers.
package mips_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LB   = 3'd2,
    MEM_LBU  = 3'd3,
    MEM_SW   = 3'd4,
    MEM_SB   = 3'd5
  } mem_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Codes 6 and 7 are unassigned and behave as MEM_NONE.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op >= 3'(MEM_LW)) && (op <= 3'(MEM_SB));
  endfunction

  function automatic logic is_store_op(input logic [2:0] op);
    return (op == 3'(MEM_SW)) || (op == 3'(MEM_SB));
  endfunction

  function automatic logic is_word_op(input logic [2:0] op);
    return (op == 3'(MEM_LW)) || (op == 3'(MEM_SW));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts and extends load data from a big-endian memory word:
// lane 0 is bits [31:24], lane 3 is bits [7:0].
module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_op,
  output logic [31:0] o_value
);

  logic [7:0] w_byte;

  assign w_byte = i_rdata[8*(3 - i_lane) +: 8];

  // NOTE: assign a default before any case/if in always_comb so that no path
  // leaves the output unassigned, which would infer a latch.
  always_comb begin
    o_value = i_rdata;
    case (i_op)
      3'(MEM_LB):  o_value = {{24{w_byte[7]}}, w_byte};
      3'(MEM_LBU): o_value = {24'h0, w_byte};
      default:     o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack bus, stalls the
// execute stage while a request is outstanding, and emits one writeback pulse per op.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_aluOut,
  input  logic [DATA_W-1:0] ex_rtData,
  input  logic [2:0]        ex_memOp,
  input  logic              ex_regWrite,
  input  logic [REG_W-1:0]  ex_destReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [REG_W-1:0]  wb_destReg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_align_err
);

  mem_state_e        r_state, w_next_state;
  logic [2:0]        r_op;
  logic              r_regWrite;
  logic [REG_W-1:0]  r_destReg;
  logic [DATA_W-1:0] r_alu;

  logic              w_accept, w_misaligned, w_issue, w_ack_done;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_load_val;

  assign ex_ready     = (r_state == ST_IDLE);
  assign w_accept     = ex_valid && ex_ready;
  assign w_lane       = ex_aluOut[1:0];
  assign w_misaligned = is_word_op(ex_memOp) && (w_lane != 2'b00);
  assign w_issue      = w_accept && is_mem_op(ex_memOp) && !w_misaligned;
  assign w_ack_done   = (r_state == ST_ACCESS) && mem_ack;

  assign w_be    = is_word_op(ex_memOp) ? 4'b1111 : (4'b1000 >> w_lane);
  assign w_wdata = (ex_memOp == 3'(MEM_SB)) ? {4{ex_rtData[7:0]}} : ex_rtData;

  mem_load_align u_load_align (
    .i_rdata (mem_rdata),
    .i_lane  (r_alu[1:0]),
    .i_op    (r_op),
    .o_value (w_load_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue) w_next_state = ST_ACCESS;
      ST_ACCESS: if (mem_ack) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_regWrite  <= 1'b0;
      wb_destReg   <= '0;
      wb_data      <= '0;
      wb_align_err <= 1'b0;
      r_op         <= 3'(MEM_NONE);
      r_regWrite   <= 1'b0;
      r_destReg    <= '0;
      r_alu        <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (w_issue) begin
        mem_req    <= 1'b1;
        mem_we     <= is_store_op(ex_memOp);
        mem_addr   <= {ex_aluOut[DATA_W-1:2], 2'b00};
        mem_wdata  <= w_wdata;
        mem_be     <= w_be;
        r_op       <= ex_memOp;
        r_regWrite <= ex_regWrite && !is_store_op(ex_memOp);
        r_destReg  <= ex_destReg;
        r_alu      <= ex_aluOut;
      end else if (w_accept) begin
        // Non-memory ops and misaligned word accesses retire immediately.
        wb_valid     <= 1'b1;
        wb_data      <= ex_aluOut;
        wb_regWrite  <= ex_regWrite && !w_misaligned;
        wb_destReg   <= ex_destReg;
        wb_align_err <= w_misaligned;
      end else if (w_ack_done) begin
        mem_req      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_data      <= is_store_op(r_op) ? r_alu : w_load_val;
        wb_regWrite  <= r_regWrite;
        wb_destReg   <= r_destReg;
        wb_align_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment and
// reset during an outstanding access, against hand-computed values.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_aluOut, ex_rtData;
  logic [2:0]  ex_memOp;
  logic        ex_regWrite;
  logic [4:0]  ex_destReg;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        wb_valid, wb_regWrite, wb_align_err;
  logic [4:0]  wb_destReg;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;
  int ready_low;

  always #5 clock = ~clock;

  mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_aluOut    (ex_aluOut),
    .ex_rtData    (ex_rtData),
    .ex_memOp     (ex_memOp),
    .ex_regWrite  (ex_regWrite),
    .ex_destReg   (ex_destReg),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .wb_valid     (wb_valid),
    .wb_regWrite  (wb_regWrite),
    .wb_destReg   (wb_destReg),
    .wb_data      (wb_data),
    .wb_align_err (wb_align_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one instruction for a single cycle; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] rt,
                       input logic rw, input logic [4:0] dest);
    ex_memOp    = op;
    ex_aluOut   = alu;
    ex_rtData   = rt;
    ex_regWrite = rw;
    ex_destReg  = dest;
    ex_valid    = 1'b1;
    tick();
    ex_valid    = 1'b0;
    ex_memOp    = 3'(MEM_NONE);
  endtask

  // Called right after issue(); ack is sampled on the n-th edge after the accept edge.
  task automatic ack_after(input int n, input logic [31:0] rdata);
    ready_low = (ex_ready == 1'b0) ? 1 : 0;
    for (int i = 1; i < n; i++) begin
      mem_rdata = 32'hBAD0_0000 + 32'(i);
      tick();
      if (!ex_ready) ready_low++;
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
  endtask

  initial begin
    reset_n     = 1'b0;
    ex_valid    = 1'b0;
    ex_aluOut   = '0;
    ex_rtData   = '0;
    ex_memOp    = 3'(MEM_NONE);
    ex_regWrite = 1'b0;
    ex_destReg  = '0;
    mem_rdata   = '0;
    mem_ack     = 1'b0;
    #12;
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_be",   32'(mem_be),   32'd0);
    check("rst_mem_addr", mem_addr,      32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data",  wb_data,       32'd0);
    reset_n = 1'b1;
    tick();
    check("rst_ready", 32'(ex_ready), 32'd1);

    // Pass-through ALU result
    issue(3'(MEM_NONE), 32'h0000_1234, 32'h0, 1'b1, 5'd5);
    check("add_wb_valid", 32'(wb_valid),    32'd1);
    check("add_wb_data",  wb_data,          32'h0000_1234);
    check("add_wb_dest",  32'(wb_destReg),  32'd5);
    check("add_wb_rw",    32'(wb_regWrite), 32'd1);
    check("add_ready",    32'(ex_ready),    32'd1);
    check("add_no_req",   32'(mem_req),     32'd0);
    tick();
    check("add_pulse_end", 32'(wb_valid), 32'd0);

    // Three back-to-back ops, one of them using unassigned code 7
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_memOp    = (i == 2) ? 3'd7 : 3'(MEM_NONE);
      ex_aluOut   = 32'h100 + 32'(i);
      ex_regWrite = 1'b1;
      ex_destReg  = 5'(10 + i);
      tick();
      check($sformatf("b2b%0d_valid", i), 32'(wb_valid),   32'd1);
      check($sformatf("b2b%0d_data", i),  wb_data,         32'h100 + 32'(i));
      check($sformatf("b2b%0d_dest", i),  32'(wb_destReg), 32'(10 + i));
      check($sformatf("b2b%0d_ready", i), 32'(ex_ready),   32'd1);
    end
    ex_valid = 1'b0;
    ex_memOp = 3'(MEM_NONE);
    check("b2b_no_req", 32'(mem_req), 32'd0);
    tick();

    // LW aligned, ack on the fourth edge after accept
    issue(3'(MEM_LW), 32'h0000_1000, 32'h0, 1'b1, 5'd7);
    check("lw_req",   32'(mem_req), 32'd1);
    check("lw_addr",  mem_addr,     32'h0000_1000);
    check("lw_be",    32'(mem_be),  32'hF);
    check("lw_we",    32'(mem_we),  32'd0);
    check("lw_wbv0",  32'(wb_valid), 32'd0);
    ack_after(4, 32'hDEAD_BEEF);
    check("lw_ready_low_cycles", 32'(ready_low), 32'd4);
    check("lw_wb_valid", 32'(wb_valid),    32'd1);
    check("lw_wb_data",  wb_data,          32'hDEAD_BEEF);
    check("lw_wb_dest",  32'(wb_destReg),  32'd7);
    check("lw_wb_rw",    32'(wb_regWrite), 32'd1);
    check("lw_req_drop", 32'(mem_req),     32'd0);
    check("lw_ready",    32'(ex_ready),    32'd1);
    tick();
    check("lw_pulse_end", 32'(wb_valid), 32'd0);
    check("lw_data_hold", wb_data,       32'hDEAD_BEEF);

    // LB / LBU from lane 1
    issue(3'(MEM_LB), 32'h0000_1001, 32'h0, 1'b1, 5'd8);
    check("lb_addr", mem_addr,    32'h0000_1000);
    check("lb_be",   32'(mem_be), 32'b0100);
    ack_after(2, 32'h11F2_3344);
    check("lb_wb_data", wb_data, 32'hFFFF_FFF2);
    issue(3'(MEM_LBU), 32'h0000_1001, 32'h0, 1'b1, 5'd9);
    ack_after(1, 32'h11F2_3344);
    check("lbu_wb_data", wb_data,         32'h0000_00F2);
    check("lbu_wb_dest", 32'(wb_destReg), 32'd9);

    // SB to lane 3
    issue(3'(MEM_SB), 32'h0000_2003, 32'h0000_00AB, 1'b1, 5'd4);
    check("sb_addr",  mem_addr,     32'h0000_2000);
    check("sb_be",    32'(mem_be),  32'b0001);
    check("sb_wdata", mem_wdata,    32'hABAB_ABAB);
    check("sb_we",    32'(mem_we),  32'd1);
    ack_after(3, 32'h0);
    check("sb_wb_valid", 32'(wb_valid),    32'd1);
    check("sb_wb_rw",    32'(wb_regWrite), 32'd0);

    // SW aligned
    issue(3'(MEM_SW), 32'h0000_3000, 32'hCAFE_F00D, 1'b0, 5'd0);
    check("sw_be",    32'(mem_be), 32'hF);
    check("sw_wdata", mem_wdata,   32'hCAFE_F00D);
    check("sw_we",    32'(mem_we), 32'd1);
    ack_after(1, 32'h0);
    check("sw_wb_rw", 32'(wb_regWrite), 32'd0);

    // SW misaligned: no request, immediate error writeback
    issue(3'(MEM_SW), 32'h0000_3002, 32'h1111_2222, 1'b1, 5'd3);
    check("swm_no_req",   32'(mem_req),      32'd0);
    check("swm_wb_valid", 32'(wb_valid),     32'd1);
    check("swm_err",      32'(wb_align_err), 32'd1);
    check("swm_wb_rw",    32'(wb_regWrite),  32'd0);
    check("swm_wb_data",  wb_data,           32'h0000_3002);
    check("swm_ready",    32'(ex_ready),     32'd1);
    tick();
    check("swm_pulse_end", 32'(wb_valid), 32'd0);

    // Reset during an outstanding LW
    issue(3'(MEM_LW), 32'h0000_4000, 32'h0, 1'b1, 5'd6);
    check("rsta_req", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rsta_req_drop", 32'(mem_req), 32'd0);
    check("rsta_addr",     mem_addr,      32'd0);
    #3 reset_n = 1'b1;
    tick();
    check("rsta_ready", 32'(ex_ready), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_wbv",   32'(wb_valid), 32'd0);
    check("stray_ack_ready", 32'(ex_ready), 32'd1);
    check("stray_ack_req",   32'(mem_req),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
